// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: link state encoding, frame length and parity helper.
// Used by both the device transmitter and the PS/2 receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } ps2_state_e;

  localparam int FRAME_BITS = 11;

  // Odd parity bit: data plus parity carries an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the open-collector PS/2 clock line.
// Resets to 1 so a released (idle) line is assumed until sampled otherwise.
module ps2_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/ps2_dev_tx.sv
// PS/2 device-to-host transmitter: generates the PS/2 clock and shifts out an
// 11-bit frame, aborting when the host inhibits the clock line mid-frame.
//
// Handshake: a byte is taken in any cycle where TX_VALID and TX_READY are both
// 1; TX_VALID may stay high, TX_READY is registered and only high while idle.
module ps2_dev_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PER = 2000,
  parameter int GAP_CYC  = 2500
) (
  input  logic       CLK_50MHZ,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_DONE,
  output logic       TX_ABORT,
  input  logic       PS2_CLK_IN,
  output logic       PS2_CLK_OUT,
  output logic       PS2_DATA_OUT,
  output ps2_state_e DBG_STATE
);

  localparam logic [15:0] HALF_LAST   = 16'(HALF_PER - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYC - 1);
  localparam logic [15:0] INHIBIT_MIN = 16'd4;
  localparam logic [3:0]  LAST_IDX    = 4'(FRAME_BITS - 1);

  ps2_state_e                  r_state;
  ps2_state_e                  w_next;
  logic [15:0]                 r_cnt;
  logic [3:0]                  r_idx;
  logic [FRAME_BITS-1:0]       r_frame;
  logic                        r_armed;
  logic                        r_ready;
  logic                        r_done;
  logic                        r_abort;
  logic                        r_clk_out;
  logic                        r_data_out;

  logic w_clk_sync;
  logic w_accept;
  logic w_phase_last;
  logic w_inhibit;
  logic w_done;
  logic w_shift;
  logic w_data_next;

  ps2_sync u_sync (
    .i_clk   (CLK_50MHZ),
    .i_rst   (RESET),
    .i_async (PS2_CLK_IN),
    .o_sync  (w_clk_sync)
  );

  // Inhibit is masked early in HIGH: the synced line still shows our own LOW.
  always_comb begin
    w_accept     = (r_state == ST_IDLE) && TX_VALID && r_ready;
    w_phase_last = (r_cnt == HALF_LAST);
    w_inhibit    = (r_state == ST_HIGH) && (r_cnt >= INHIBIT_MIN) &&
                   (r_idx < LAST_IDX) && !w_clk_sync;
    w_done       = (r_state == ST_LOW) && w_phase_last && (r_idx == LAST_IDX);
    w_shift      = (r_state == ST_LOW) && w_phase_last && (r_idx != LAST_IDX);
    w_next       = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_HIGH;
      ST_HIGH: begin
        if (w_inhibit)         w_next = ST_GAP;
        else if (w_phase_last) w_next = ST_LOW;
      end
      ST_LOW: begin
        if (w_done)       w_next = ST_GAP;
        else if (w_shift) w_next = ST_HIGH;
      end
      ST_GAP:  if (r_cnt == GAP_LAST) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    w_data_next = 1'b1;
    if (w_accept)                                 w_data_next = 1'b0;
    else if (w_shift)                             w_data_next = r_frame[1];
    else if (w_next == ST_HIGH || w_next == ST_LOW) w_data_next = r_frame[0];
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_frame    <= '1;
      r_armed    <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_clk_out  <= 1'b1;
      r_data_out <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || r_state == ST_IDLE) r_cnt <= '0;
      else                                         r_cnt <= r_cnt + 16'd1;
      if (w_accept) begin
        r_frame <= {1'b1, odd_parity(TX_DATA), TX_DATA, 1'b0};
        r_idx   <= '0;
      end else if (w_shift) begin
        r_frame <= {1'b1, r_frame[FRAME_BITS-1:1]};
        r_idx   <= r_idx + 4'd1;
      end
      r_armed    <= 1'b1;
      r_ready    <= r_armed && (w_next == ST_IDLE) && w_clk_sync;
      r_done     <= w_done;
      r_abort    <= w_inhibit;
      r_clk_out  <= (w_next != ST_LOW);
      r_data_out <= w_data_next;
    end
  end

  assign TX_READY     = r_ready;
  assign TX_DONE      = r_done;
  assign TX_ABORT     = r_abort;
  assign PS2_CLK_OUT  = r_clk_out;
  assign PS2_DATA_OUT = r_data_out;
  assign DBG_STATE    = r_state;

endmodule
